// File: rtl/cpu_edu_pkg.sv
// Shared fetch-path constants and the buffered fetch entry (instruction word plus its PC).
package cpu_edu_pkg;

    localparam int ADDR_W = 16;
    localparam int INSTR_W = 16;
    localparam logic [ADDR_W-1:0] RESET_PC = 16'h0000;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries: head visible the cycle after push, push/pop same cycle keeps count.
// Flush (and reset) empties it and wins over push; the caller must never push when full.
module fetch_fifo
    import cpu_edu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  fetch_entry_t               din,
    input  logic                       pop,
    input  logic                       flush,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output fetch_entry_t               head
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    fetch_entry_t    mem [DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign head = mem[rd_ptr];

    // The fetch credit check upstream is what keeps this from ever firing.
    assert property (@(posedge clk) disable iff (rst || flush) !(push && count == CW'(DEPTH)));

endmodule

// File: rtl/instr_prefetch_unit.sv
// Prefetch from a 1-cycle ROM into a small FIFO; first word valid 2 cycles after reset, 3 after redirect.
// Decode backpressure holds the head; fetch stops once buffered plus in-flight words fill the FIFO.
module instr_prefetch_unit
    import cpu_edu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [INSTR_W-1:0] rom_data,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc
);

    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW:0] DEPTH_V = DEPTH[CW:0];

    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] issue_pc_q;
    logic              issue_q;
    logic              issue;
    logic              push;
    logic              pop;
    logic [CW-1:0]     count;
    logic [CW:0]       in_use;
    fetch_entry_t      head;
    fetch_entry_t      din;

    // The in-flight ROM read already owns a slot, so it counts against the credit.
    assign in_use      = {1'b0, count} + {{CW{1'b0}}, issue_q};
    assign issue       = !redirect && (in_use < DEPTH_V);
    assign push        = issue_q && !redirect;
    assign instr_valid = (count != '0);
    assign pop         = instr_valid && instr_ready;
    assign din         = {rom_data, issue_pc_q};
    assign rom_addr    = fetch_pc;
    assign instr       = instr_valid ? head.instr : '0;
    assign instr_pc    = instr_valid ? head.pc : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc   <= RESET_PC;
            issue_q    <= 1'b0;
            issue_pc_q <= '0;
        end else if (redirect) begin
            fetch_pc <= redirect_pc;
            issue_q  <= 1'b0;
        end else if (issue) begin
            fetch_pc   <= fetch_pc + ADDR_W'(1);
            issue_q    <= 1'b1;
            issue_pc_q <= fetch_pc;
        end else begin
            issue_q <= 1'b0;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (din),
        .pop   (pop),
        .flush (redirect),
        .count (count),
        .head  (head)
    );

endmodule

// File: tb/tb_instr_prefetch_unit.sv
// Directed bench for instr_prefetch_unit: expected PCs queued by stimulus, checked by a negedge monitor.
module tb_instr_prefetch_unit;
    import cpu_edu_pkg::*;

    localparam int DEPTH = 4;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [ADDR_W-1:0]  rom_addr;
    logic [INSTR_W-1:0] rom_data;
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  instr_pc;
    logic               instr_valid;
    logic               instr_ready = 1'b0;
    logic               redirect = 1'b0;
    logic [ADDR_W-1:0]  redirect_pc = '0;

    int n_chk = 0;
    int n_fail = 0;
    int n_xfer = 0;
    logic armed = 1'b0;
    logic [15:0] exp_q[$];

    instr_prefetch_unit #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc)
    );

    always #5 clk = ~clk;

    // Synchronous ROM: mem[a] = a ^ A5A5
    always @(posedge clk) rom_data <= rom_addr ^ 16'hA5A5;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every transfer must match the head of the expected queue.
    always @(negedge clk) begin
        if (armed && !rst) begin
            if (!instr_valid) begin
                check("idle_outputs_zero", {instr, instr_pc}, 32'h0);
            end else if (instr_ready) begin
                n_xfer++;
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_xfer: got pc %h, required no transfer", instr_pc);
                end else begin
                    logic [15:0] e;
                    e = exp_q.pop_front();
                    check("xfer_pc", {16'h0, instr_pc}, {16'h0, e});
                    check("xfer_instr", {16'h0, instr}, {16'h0, e ^ 16'hA5A5});
                end
            end
        end
    end

    task automatic expect_range(input logic [15:0] start, input int n);
        logic [15:0] p;
        p = start;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(p);
            p = p + 16'd1;
        end
    endtask

    // Leaves the bench at #1 into C0 (first cycle with rst low).
    task automatic do_reset();
        instr_ready = 1'b0;
        redirect    = 1'b0;
        rst         = 1'b1;
        tick();
        check("rst_valid", {31'h0, instr_valid}, 32'h0);
        check("rst_instr_pc", {instr, instr_pc}, 32'h0);
        rst   = 1'b0;
        armed = 1'b1;
        check("c0_rom_addr", {16'h0, rom_addr}, {16'h0, RESET_PC});
    endtask

    task automatic end_test(input string name, input int x0, input int n);
        check({name, "_xfer_count"}, n_xfer - x0, n);
        check({name, "_queue_empty"}, exp_q.size(), 0);
    endtask

    // Called at cycle R with ready already set; streams n words from pc.
    task automatic redirect_and_stream(input logic [15:0] pc, input int n);
        redirect    = 1'b1;
        redirect_pc = pc;
        expect_range(pc, n);
        tick();
        redirect = 1'b0;
        check("r1_valid", {31'h0, instr_valid}, 32'h0);
        check("r1_rom_addr", {16'h0, rom_addr}, {16'h0, pc});
        tick();
        check("r2_valid", {31'h0, instr_valid}, 32'h0);
        tick();
        check("r3_valid", {31'h0, instr_valid}, 32'h1);
        check("r3_pc", {16'h0, instr_pc}, {16'h0, pc});
        repeat (n) tick();
        instr_ready = 1'b0;
    endtask

    initial begin
        int x0;

        // 1: streaming from reset, one word per cycle from C2
        do_reset();
        x0 = n_xfer;
        expect_range(16'h0000, 20);
        instr_ready = 1'b1;
        tick();
        check("c1_valid", {31'h0, instr_valid}, 32'h0);
        tick();
        check("c2_valid", {31'h0, instr_valid}, 32'h1);
        check("c2_pc", {16'h0, instr_pc}, 32'h0);
        repeat (20) tick();
        instr_ready = 1'b0;
        end_test("stream", x0, 20);

        // 2: stall holds head; fetch stops at DEPTH buffered words
        do_reset();
        tick();
        tick();
        check("stall_c2_valid", {31'h0, instr_valid}, 32'h1);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("stall_pc", {16'h0, instr_pc}, 32'h0);
        end
        check("stall_rom_addr", {16'h0, rom_addr}, DEPTH);
        tick();
        check("stall_rom_addr_hold", {16'h0, rom_addr}, DEPTH);
        x0 = n_xfer;
        expect_range(16'h0000, 12);
        instr_ready = 1'b1;
        repeat (12) tick();
        instr_ready = 1'b0;
        end_test("release", x0, 12);

        // 3: redirect while pc 5 is consumed
        do_reset();
        x0 = n_xfer;
        expect_range(16'h0000, 6);
        instr_ready = 1'b1;
        repeat (7) tick();
        check("redir_head_pc", {16'h0, instr_pc}, 32'h5);
        redirect_and_stream(16'h0040, 8);
        end_test("redirect", x0, 14);

        // 4: address wrap after redirect
        do_reset();
        x0 = n_xfer;
        instr_ready = 1'b1;
        redirect_and_stream(16'hFFFE, 4);
        end_test("wrap", x0, 4);

        // 5: reset mid-stream with FIFO full
        do_reset();
        repeat (8) tick();
        check("full_rom_addr", {16'h0, rom_addr}, DEPTH);
        check("full_valid", {31'h0, instr_valid}, 32'h1);
        do_reset();
        x0 = n_xfer;
        expect_range(16'h0000, 3);
        instr_ready = 1'b1;
        tick();
        tick();
        check("restart_valid", {31'h0, instr_valid}, 32'h1);
        check("restart_pc", {16'h0, instr_pc}, {16'h0, RESET_PC});
        repeat (3) tick();
        instr_ready = 1'b0;
        end_test("restart", x0, 3);

        // 6: back-to-back redirects, last wins
        do_reset();
        x0 = n_xfer;
        instr_ready = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 16'h0010;
        tick();
        redirect_and_stream(16'h0020, 4);
        end_test("b2b_redirect", x0, 4);

        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "timeout");
    end

endmodule
